disp_frame_check: RTL and testbench
===================================

# disp_frame_check

Display-stream sink that sits on the pixel side of a chapter design, in parallel with the board video output, and consumes the same `disp_*` signals the design drives. It accumulates a CRC-32 over every active pixel of a frame and counts the pixels. It checks raster order and frame size, then reports one result per completed frame. Simulation tops and hardware self-test use it for golden-frame regression without inspecting pixels individually.

## Interface
Parameters:
- `BPC`, 5, bits per colour channel
- `CORDW`, 16, signed coordinate width (bits)
- `H_RES`, 672, expected active pixels per line
- `V_RES`, 384, expected active lines per frame

Ports:
- `clk_pix` input 1: pixel clock; the only clock.
- `rst_pix` input 1: reset, asynchronous and active-high.
- `disp_x` input CORDW, signed: horizontal position.
- `disp_y` input CORDW, signed: vertical position.
- `disp_de` input 1: data enable; a pixel is active when this is high.
- `disp_frame` input 1: high for one cycle at frame start.
- `disp_r`, `disp_g`, `disp_b` input BPC each: colour channels.
- `res_valid` output 1: one-cycle pulse; the `res_*` outputs hold a new frame result.
- `res_crc` output 32: CRC-32 of the completed frame.
- `res_pixels` output 32: active pixel count of the completed frame.
- `res_frame` output 32: index of the completed frame.
- `res_err_order` output 1: the completed frame contained an out-of-order pixel.
- `res_err_size` output 1: `res_pixels` ≠ H_RES×V_RES.

## Operation
- **States**
  - SYNC: entered on reset. Ignores `disp_de` and does not accumulate.
  - RUN: entered on the first `disp_frame` seen in SYNC. That frame produces no result.
- **CRC**
  - Polynomial 0x04C11DB7, init 0xFFFFFFFF, no reflection, final XOR 0xFFFFFFFF.
  - Each active pixel contributes the 3×BPC-bit word {r,g,b}, MSB first.
  - The full word is folded in one cycle.
- **Pixel count**
  - Increments on every active pixel in RUN.
  - Saturates at 0xFFFFFFFF.
- **Order check**
  - Expected position (ex,ey) resets to (0,0) at each `disp_frame`.
  - On each active pixel, if (disp_x,disp_y) ≠ (ex,ey), set the sticky `err_order` accumulator.
  - Then set the expected position to the observed position advanced by one: x+1, or (0, y+1) when x+1 = H_RES. This resynchronises the check so a single glitch flags once and leaves the rest of the frame clean.
- **Frame boundary** (`disp_frame` in RUN)
  - Latch the final CRC, count, order flag and size check (count ≠ H_RES×V_RES) into the `res_*` registers.
  - Latch the `res_frame` value, then increment the frame counter.
  - Reload the CRC to init and clear the count and error accumulator.
- **Frame counter**
  - 32-bit; wraps to 0 after 0xFFFFFFFF.
  - The first reported frame has `res_frame` = 0.
- **Simultaneous `disp_frame` and `disp_de`**
  - The boundary is processed first.
  - The pixel is then the first pixel of the new frame: it is checked against (0,0) and folded into the fresh CRC/count.
- **Reset mid-operation**
  - All state returns to SYNC and all outputs go to 0.
  - The partial frame is discarded and the next `disp_frame` only re-arms.
  - The frame counter restarts at 0.

## Timing
- All outputs are registered, and every output is 0 at reset.
- Result latency: `res_valid` is high in the cycle after the `disp_frame` cycle, for exactly one cycle.
- The `res_*` data outputs hold their value until the next result; there is no back-pressure.
- The last pixel before `disp_frame` may be in the immediately preceding cycle and must be included in that frame's result.
- Accumulator update latency is 1 cycle per active pixel. The block sustains one pixel per clock continuously.

## Test plan
- **Arming**
  - Stimulus: reset, then a full 672×384 frame, then `disp_frame`.
  - Required: the first `disp_frame` gives no `res_valid`. The second gives `res_valid` 1 cycle later with `res_pixels`=258048, `res_frame`=0, both errors 0, and `res_crc` equal to the software model.
- **Repeatability**
  - Stimulus: three identical frames.
  - Required: identical `res_crc`, `res_frame` = 0,1; a single flipped bit of `disp_b` at (100,50) in frame 3 changes `res_crc`.
- **Order error**
  - Stimulus: skip pixel (5,0) with `de` low, then resume at (6,0).
  - Required: `res_err_order`=1 and `res_err_size`=1 (`res_pixels`=258047); the next clean frame reports both errors 0.
- **Boundary coincidence**
  - Stimulus: H_RES=4, V_RES=2 with `disp_frame` and `disp_de` asserted together at (0,0).
  - Required: `res_pixels`=8 with no order error.
- **Reset mid-frame**
  - Stimulus: assert `rst_pix` asynchronously halfway through a frame.
  - Required: all outputs are 0 immediately. The next `disp_frame` produces no result, and the following one reports `res_frame`=0.

Source files
------------

// File: rtl/disp_frame_check.sv
// Display-stream frame checker: CRC-32 and pixel count per frame, raster-order
// and frame-size checks, one registered result per completed frame.
module disp_frame_check #(
  parameter int BPC   = 5,
  parameter int CORDW = 16,
  parameter int H_RES = 672,
  parameter int V_RES = 384
) (
  input  logic                    clk_pix,
  input  logic                    rst_pix,
  input  logic signed [CORDW-1:0] disp_x,
  input  logic signed [CORDW-1:0] disp_y,
  input  logic                    disp_de,
  input  logic                    disp_frame,
  input  logic [BPC-1:0]          disp_r,
  input  logic [BPC-1:0]          disp_g,
  input  logic [BPC-1:0]          disp_b,
  output logic                    res_valid,
  output logic [31:0]             res_crc,
  output logic [31:0]             res_pixels,
  output logic [31:0]             res_frame,
  output logic                    res_err_order,
  output logic                    res_err_size
);

  localparam int          PW        = 3 * BPC;
  localparam logic [31:0] POLY      = 32'h04C1_1DB7;
  localparam logic [31:0] CRC_INIT  = 32'hFFFF_FFFF;
  localparam logic [31:0] FRAME_PIX = 32'(H_RES * V_RES);

  typedef enum logic {SYNC, RUN} state_t;

  state_t                    state_q, state_d;
  logic [31:0]               crc_q, crc_d, cnt_q, cnt_d, fcnt_q, fcnt_d;
  logic                      err_q, err_d;
  logic signed [CORDW-1:0]   ex_q, ex_d, ey_q, ey_d;
  logic                      valid_q, valid_d, eo_q, eo_d, es_q, es_d;
  logic [31:0]               rcrc_q, rcrc_d, rpix_q, rpix_d, rfrm_q, rfrm_d;

  logic [31:0]               crc_b, cnt_b;
  logic                      err_b;
  logic signed [CORDW-1:0]   ex_b, ey_b, x_inc;

  // Whole pixel word folded MSB first, one bit per loop iteration.
  function automatic logic [31:0] crc_fold(input logic [31:0] c, input logic [PW-1:0] w);
    logic [31:0] r;
    r = c;
    for (int i = PW - 1; i >= 0; i--)
      r = {r[30:0], 1'b0} ^ ((r[31] ^ w[i]) ? POLY : 32'h0);
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    crc_d   = crc_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    ex_d    = ex_q;
    ey_d    = ey_q;
    fcnt_d  = fcnt_q;
    valid_d = 1'b0;
    eo_d    = eo_q;
    es_d    = es_q;
    rcrc_d  = rcrc_q;
    rpix_d  = rpix_q;
    rfrm_d  = rfrm_q;
    crc_b   = crc_q;
    cnt_b   = cnt_q;
    err_b   = err_q;
    ex_b    = ex_q;
    ey_b    = ey_q;
    x_inc   = disp_x + CORDW'(1);

    if (state_q == RUN && disp_frame) begin
      valid_d = 1'b1;
      rcrc_d  = crc_q ^ 32'hFFFF_FFFF;
      rpix_d  = cnt_q;
      rfrm_d  = fcnt_q;
      fcnt_d  = fcnt_q + 32'd1;
      eo_d    = err_q;
      es_d    = (cnt_q != FRAME_PIX);
    end

    // Boundary first, so a pixel in the same cycle opens the new frame.
    if (disp_frame) begin
      state_d = RUN;
      crc_b   = CRC_INIT;
      cnt_b   = 32'd0;
      err_b   = 1'b0;
      ex_b    = '0;
      ey_b    = '0;
    end

    if (disp_de && (state_q == RUN || disp_frame)) begin
      crc_d = crc_fold(crc_b, {disp_r, disp_g, disp_b});
      cnt_d = (cnt_b == 32'hFFFF_FFFF) ? cnt_b : cnt_b + 32'd1;
      err_d = err_b | (disp_x != ex_b) | (disp_y != ey_b);
      if (x_inc == CORDW'(H_RES)) begin
        ex_d = '0;
        ey_d = disp_y + CORDW'(1);
      end else begin
        ex_d = x_inc;
        ey_d = disp_y;
      end
    end else begin
      crc_d = crc_b;
      cnt_d = cnt_b;
      err_d = err_b;
      ex_d  = ex_b;
      ey_d  = ey_b;
    end
  end

  always_ff @(posedge clk_pix or posedge rst_pix) begin
    if (rst_pix) begin
      state_q <= SYNC;
      crc_q   <= 32'd0;
      cnt_q   <= 32'd0;
      err_q   <= 1'b0;
      ex_q    <= '0;
      ey_q    <= '0;
      fcnt_q  <= 32'd0;
      valid_q <= 1'b0;
      eo_q    <= 1'b0;
      es_q    <= 1'b0;
      rcrc_q  <= 32'd0;
      rpix_q  <= 32'd0;
      rfrm_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      crc_q   <= crc_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      ex_q    <= ex_d;
      ey_q    <= ey_d;
      fcnt_q  <= fcnt_d;
      valid_q <= valid_d;
      eo_q    <= eo_d;
      es_q    <= es_d;
      rcrc_q  <= rcrc_d;
      rpix_q  <= rpix_d;
      rfrm_q  <= rfrm_d;
    end
  end

  assign res_valid     = valid_q;
  assign res_crc       = rcrc_q;
  assign res_pixels    = rpix_q;
  assign res_frame     = rfrm_q;
  assign res_err_order = eo_q;
  assign res_err_size  = es_q;

endmodule

// File: tb/tb_disp_frame_check.sv
// Directed bench for disp_frame_check: an 8x4 instance for the main flows and a
// 4x2 instance for the frame/pixel coincidence case, fed from one shared stream.
module tb_disp_frame_check;
  localparam int BPC = 5, CORDW = 16, HA = 8, VA = 4, HB = 4, VB = 2;

  logic                    clk_pix = 1'b0;
  logic                    rst_pix = 1'b1;
  logic signed [CORDW-1:0] disp_x = '0, disp_y = '0;
  logic                    disp_de = 1'b0, disp_frame = 1'b0;
  logic [BPC-1:0]          disp_r = '0, disp_g = '0, disp_b = '0;

  logic        a_valid, a_eo, a_es, b_valid, b_eo, b_es;
  logic [31:0] a_crc, a_pix, a_frm, b_crc, b_pix, b_frm;

  int          checks = 0, failures = 0;
  logic [31:0] exp_crc, exp_cnt, fin, crc_a, fin1;

  disp_frame_check #(.BPC(BPC), .CORDW(CORDW), .H_RES(HA), .V_RES(VA)) u_dut_a (
    .clk_pix(clk_pix), .rst_pix(rst_pix), .disp_x(disp_x), .disp_y(disp_y),
    .disp_de(disp_de), .disp_frame(disp_frame), .disp_r(disp_r), .disp_g(disp_g),
    .disp_b(disp_b), .res_valid(a_valid), .res_crc(a_crc), .res_pixels(a_pix),
    .res_frame(a_frm), .res_err_order(a_eo), .res_err_size(a_es));

  disp_frame_check #(.BPC(BPC), .CORDW(CORDW), .H_RES(HB), .V_RES(VB)) u_dut_b (
    .clk_pix(clk_pix), .rst_pix(rst_pix), .disp_x(disp_x), .disp_y(disp_y),
    .disp_de(disp_de), .disp_frame(disp_frame), .disp_r(disp_r), .disp_g(disp_g),
    .disp_b(disp_b), .res_valid(b_valid), .res_crc(b_crc), .res_pixels(b_pix),
    .res_frame(b_frm), .res_err_order(b_eo), .res_err_size(b_es));

  always #5 clk_pix = ~clk_pix;

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [14:0] w);
    logic [31:0] r;
    r = c;
    for (int i = 14; i >= 0; i--) begin
      if (r[31] ^ w[i]) r = (r << 1) ^ 32'h04C1_1DB7;
      else              r = r << 1;
    end
    return r;
  endfunction

  function automatic logic [14:0] colour(input int x, input int y, input int seed);
    return {5'(x + seed), 5'(y * 3 + 1), 5'(x * y + seed * 7)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_res(input string t, input logic v, input logic [31:0] crc,
                           input logic [31:0] pix, input logic [31:0] frm, input logic eo,
                           input logic es, input logic [31:0] ecrc, input logic [31:0] epix,
                           input logic [31:0] efrm, input logic eeo, input logic ees);
    check({t, "_valid"}, 32'(v), 32'd1);
    check({t, "_crc"}, crc, ecrc);
    check({t, "_pixels"}, pix, epix);
    check({t, "_frame"}, frm, efrm);
    check({t, "_err_order"}, 32'(eo), 32'(eeo));
    check({t, "_err_size"}, 32'(es), 32'(ees));
  endtask

  task automatic drive(input logic f, input logic de, input int x, input int y,
                       input logic [14:0] w);
    @(negedge clk_pix);
    disp_frame = f;
    disp_de    = de;
    disp_x     = 16'(x);
    disp_y     = 16'(y);
    {disp_r, disp_g, disp_b} = w;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 0, 0, 15'd0);
  endtask

  task automatic start_model();
    exp_crc = 32'hFFFF_FFFF;
    exp_cnt = 32'd0;
  endtask

  task automatic model_pix(input logic [14:0] w);
    exp_crc = crc_step(exp_crc, w);
    exp_cnt = exp_cnt + 32'd1;
  endtask

  // Linear pixel indices [first..last]; flip inverts bit 0 of blue, skip drops de.
  task automatic send_range(input int h, input int seed, input int flip, input int skip,
                            input int first, input int last);
    logic [14:0] w;
    for (int n = first; n <= last; n++) begin
      w = colour(n % h, n / h, seed);
      if (n == flip) w[0] = ~w[0];
      if (n == skip) drive(1'b0, 1'b0, n % h, n / h, w);
      else begin
        drive(1'b0, 1'b1, n % h, n / h, w);
        model_pix(w);
      end
    end
  endtask

  task automatic check_outputs_zero(input string t);
    check({t, "_valid"}, 32'(a_valid), 32'd0);
    check({t, "_crc"}, a_crc, 32'd0);
    check({t, "_pixels"}, a_pix, 32'd0);
    check({t, "_frame"}, a_frm, 32'd0);
    check({t, "_err_order"}, 32'(a_eo), 32'd0);
    check({t, "_err_size"}, 32'(a_es), 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk_pix);
    check_outputs_zero("reset");
    check("reset_b_valid", 32'(b_valid), 32'd0);
    @(negedge clk_pix);
    rst_pix = 1'b0;

    drive(1'b1, 1'b0, 0, 0, 15'd0);
    idle();
    check("arm_no_result", 32'(a_valid), 32'd0);

    start_model();
    send_range(HA, 0, -1, -1, 0, HA * VA - 1);
    fin = exp_crc ^ 32'hFFFF_FFFF;
    crc_a = fin;
    drive(1'b1, 1'b0, 0, 0, 15'd0);
    idle();
    check_res("f0", a_valid, a_crc, a_pix, a_frm, a_eo, a_es, fin, 32'd32, 32'd0, 1'b0, 1'b0);
    idle();
    check("f0_pulse_one_cycle", 32'(a_valid), 32'd0);
    check("f0_crc_held", a_crc, crc_a);

    start_model();
    send_range(HA, 0, -1, -1, 0, HA * VA - 1);
    fin = exp_crc ^ 32'hFFFF_FFFF;
    drive(1'b1, 1'b0, 0, 0, 15'd0);
    idle();
    check_res("f1", a_valid, a_crc, a_pix, a_frm, a_eo, a_es, fin, 32'd32, 32'd1, 1'b0, 1'b0);
    check("f1_repeat_crc", a_crc, crc_a);

    start_model();
    send_range(HA, 0, 2 * HA + 5, -1, 0, HA * VA - 1);
    fin = exp_crc ^ 32'hFFFF_FFFF;
    drive(1'b1, 1'b0, 0, 0, 15'd0);
    idle();
    check_res("f2", a_valid, a_crc, a_pix, a_frm, a_eo, a_es, fin, 32'd32, 32'd2, 1'b0, 1'b0);
    check("f2_flip_changes_crc", 32'(a_crc != crc_a), 32'd1);

    start_model();
    send_range(HA, 1, -1, 5, 0, HA * VA - 1);
    fin = exp_crc ^ 32'hFFFF_FFFF;
    drive(1'b1, 1'b0, 0, 0, 15'd0);
    idle();
    check_res("skip", a_valid, a_crc, a_pix, a_frm, a_eo, a_es, fin, 32'd31, 32'd3, 1'b1, 1'b1);

    start_model();
    send_range(HA, 2, -1, -1, 0, HA * VA - 1);
    fin = exp_crc ^ 32'hFFFF_FFFF;
    drive(1'b1, 1'b0, 0, 0, 15'd0);
    idle();
    check_res("clean", a_valid, a_crc, a_pix, a_frm, a_eo, a_es, fin, 32'd32, 32'd4, 1'b0, 1'b0);

    start_model();
    send_range(HA, 3, -1, -1, 0, 15);
    #2 rst_pix = 1'b1;
    #1 check_outputs_zero("midrst");
    @(negedge clk_pix);
    rst_pix = 1'b0;
    idle();
    drive(1'b1, 1'b0, 0, 0, 15'd0);
    idle();
    check("midrst_rearm_no_result", 32'(a_valid), 32'd0);
    start_model();
    send_range(HA, 3, -1, -1, 0, HA * VA - 1);
    fin = exp_crc ^ 32'hFFFF_FFFF;
    drive(1'b1, 1'b0, 0, 0, 15'd0);
    idle();
    check_res("midrst_f0", a_valid, a_crc, a_pix, a_frm, a_eo, a_es, fin, 32'd32, 32'd0, 1'b0, 1'b0);

    @(negedge clk_pix);
    rst_pix = 1'b1;
    @(negedge clk_pix);
    rst_pix = 1'b0;
    drive(1'b1, 1'b0, 0, 0, 15'd0);
    idle();
    check("coin_arm_no_result", 32'(b_valid), 32'd0);
    start_model();
    send_range(HB, 5, -1, -1, 0, HB * VB - 1);
    fin1 = exp_crc ^ 32'hFFFF_FFFF;
    start_model();
    drive(1'b1, 1'b1, 0, 0, colour(0, 0, 6));
    model_pix(colour(0, 0, 6));
    send_range(HB, 6, -1, -1, 1, 1);
    check_res("coin0", b_valid, b_crc, b_pix, b_frm, b_eo, b_es, fin1, 32'd8, 32'd0, 1'b0, 1'b0);
    send_range(HB, 6, -1, -1, 2, HB * VB - 1);
    fin = exp_crc ^ 32'hFFFF_FFFF;
    drive(1'b1, 1'b0, 0, 0, 15'd0);
    idle();
    check_res("coin1", b_valid, b_crc, b_pix, b_frm, b_eo, b_es, fin, 32'd8, 32'd1, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
